// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, counter width and default delay lengths for the alarm entry timer.
// ALARM_EXIT_DELAY_EN adds the EXIT state to the encoding.
package alarm_pkg;
    localparam int CNT_W = 4;
    localparam int ENTRY_TICKS_DEF = 10;
    localparam int EXIT_TICKS_DEF = 8;
`ifdef ALARM_EXIT_DELAY_EN
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_ENTRY, S_ALARM, S_EXIT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_ENTRY, S_ALARM} state_t;
`endif
endpackage

// File: rtl/tick_edge_detect.sv
// tick_edge_detect: one-clock rise pulse from a level input; history resets to 0 so a level already high counts.
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic in_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) in_q <= 1'b0;
        else in_q <= in;
    assign rise = in & ~in_q;
endmodule

// File: rtl/alarm_entry_timer.sv
// alarm_entry_timer: arm/entry-delay/alarm sequencer counting prescaler tick edges.
// Defining ALARM_EXIT_DELAY_EN inserts an EXIT delay between IDLE and ARMED.
module alarm_entry_timer
    import alarm_pkg::*;
#(
    parameter int ENTRY_TICKS = ENTRY_TICKS_DEF,
    parameter int EXIT_TICKS = EXIT_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             arm,
    input  logic             disarm,
    input  logic             sensor,
    output logic             armed,
    output logic             pending,
    output logic             siren,
    output logic [CNT_W-1:0] remaining
);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS);
    if (ENTRY_TICKS < 1 || ENTRY_TICKS > 15) begin : g_bad_entry
        $error("ENTRY_TICKS must be 1..15");
    end
    if (EXIT_TICKS < 1 || EXIT_TICKS > 15) begin : g_bad_exit
        $error("EXIT_TICKS must be 1..15");
    end
`ifdef ALARM_EXIT_DELAY_EN
    localparam logic [CNT_W-1:0] EXIT_LOAD = CNT_W'(EXIT_TICKS);
`endif
    state_t state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic tick_rise;
    tick_edge_detect u_tick (
        .clk (clk),
        .rst (rst),
        .in  (tick),
        .rise(tick_rise)
    );
    // disarm wins over everything; count only moves on a tick edge and never below zero
    always_comb begin
        nxt_state = state;
        nxt_cnt = cnt;
        if (disarm) begin
            nxt_state = S_IDLE;
            nxt_cnt = '0;
        end else begin
            case (state)
                S_IDLE:
                    if (arm) begin
`ifdef ALARM_EXIT_DELAY_EN
                        nxt_state = S_EXIT;
                        nxt_cnt = EXIT_LOAD;
`else
                        nxt_state = S_ARMED;
`endif
                    end
                S_ARMED:
                    if (sensor) begin
                        nxt_state = S_ENTRY;
                        nxt_cnt = ENTRY_LOAD;
                    end
                S_ENTRY:
                    if (tick_rise && cnt != '0) begin
                        nxt_cnt = cnt - 1'b1;
                        nxt_state = (cnt == 1) ? S_ALARM : S_ENTRY;
                    end
`ifdef ALARM_EXIT_DELAY_EN
                S_EXIT:
                    if (tick_rise && cnt != '0) begin
                        nxt_cnt = cnt - 1'b1;
                        nxt_state = (cnt == 1) ? S_ARMED : S_EXIT;
                    end
`endif
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            armed <= 1'b0;
            pending <= 1'b0;
            siren <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt <= nxt_cnt;
            armed <= nxt_state == S_ARMED || nxt_state == S_ENTRY || nxt_state == S_ALARM;
`ifdef ALARM_EXIT_DELAY_EN
            pending <= nxt_state == S_ENTRY || nxt_state == S_EXIT;
`else
            pending <= nxt_state == S_ENTRY;
`endif
            siren <= nxt_state == S_ALARM;
        end
    assign remaining = cnt;
endmodule

// File: doc/alarm_entry_timer.md
ALARM_ENTRY_TIMER -- requirements
Module: alarm_entry_timer

Interface
REQ-001 SHALL have parameter ENTRY_TICKS, default 10, entry-delay length in tick edges (legal 1..15).
REQ-002 SHALL have parameter EXIT_TICKS, default 8, exit-delay length in tick edges (legal 1..15; used only with ALARM_EXIT_DELAY_EN).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port tick, input, 1, terminal-count pulse from the 4-bit prescaler counter; the block consumes its rising edges.
REQ-006 SHALL have port arm, input, 1, arm request, level sampled per clock.
REQ-007 SHALL have port disarm, input, 1, disarm request, level sampled per clock.
REQ-008 SHALL have port sensor, input, 1, door/motion trip, level sampled per clock.
REQ-009 SHALL have port armed, output, 1, high in ARMED, ENTRY and ALARM.
REQ-010 SHALL have port pending, output, 1, high in ENTRY (and EXIT when compiled in).
REQ-011 SHALL have port siren, output, 1, high only in ALARM.
REQ-012 SHALL have port remaining, output, 4, delay count left in ENTRY/EXIT; 0 in all other states.

Function
REQ-013 SHALL register tick into tick_q and define tick_rise = tick & ~tick_q; a tick held high for N cycles counts once.
REQ-014 SHALL implement states IDLE, ARMED, ENTRY, ALARM (plus EXIT when configured); all outputs registered or decoded from state/count only.
REQ-015 IDLE: arm=1 and disarm=0 -> ARMED next cycle; otherwise stay.
REQ-016 ARMED: disarm=1 -> IDLE; else sensor=1 -> ENTRY with count loaded to ENTRY_TICKS.
REQ-017 ENTRY: disarm=1 -> IDLE; else on tick_rise decrement count; tick_rise with count==1 -> ALARM, count cleared to 0.
REQ-018 ALARM: siren held until disarm=1 -> IDLE; sensor and tick ignored.
REQ-019 disarm SHALL have priority over arm, sensor and tick_rise in the same cycle, in every state.
REQ-020 tick_rise in the cycle of ARMED->ENTRY SHALL NOT be counted; siren asserts exactly one clock after the edge that consumes the ENTRY_TICKS-th counted tick_rise.
REQ-021 sensor toggling during ENTRY SHALL NOT reload or extend the count.
REQ-022 count SHALL never underflow or wrap; arithmetic is 4-bit unsigned.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, count=0, tick_q=0, armed=0, pending=0, siren=0, remaining=0, including mid-ENTRY or in ALARM.
REQ-024 After rst release, a tick already high SHALL count as a rising edge on the first clock (tick_q reset is 0).

Configuration
REQ-025 With ALARM_EXIT_DELAY_EN defined: IDLE arm -> EXIT, count loaded to EXIT_TICKS, pending=1, armed=0; EXIT decrements on tick_rise, reaching 0 -> ARMED; sensor ignored in EXIT; disarm -> IDLE.
REQ-026 Without ALARM_EXIT_DELAY_EN: no EXIT state or logic; IDLE arm -> ARMED directly; EXIT_TICKS unused.

Structure
REQ-027 Shared package alarm_pkg SHALL hold the state enumeration, CNT_W=4 and default tick constants.
REQ-028 Edge detection SHALL be a sub-module tick_edge_detect (clk, rst, in, rise).

Verification
REQ-029 Arm, sensor pulse, tick 1 cycle high every 16 clocks, ENTRY_TICKS=10 -> pending for 10 ticks, remaining 10..1, siren high one clock after 10th tick edge.
REQ-030 Same, disarm asserted after 5th tick -> IDLE next clock, siren never asserts, remaining=0.
REQ-031 tick held high 40 cycles during ENTRY -> remaining decrements by exactly 1.
REQ-032 arm and disarm both high in IDLE; disarm together with 10th tick_rise -> stays/returns IDLE, siren=0.
REQ-033 rst pulsed asynchronously mid-ENTRY with remaining=3 and in ALARM -> all outputs 0 immediately, IDLE.
REQ-034 ALARM_EXIT_DELAY_EN, EXIT_TICKS=8: arm, sensor high during EXIT -> ARMED after 8 tick edges, no ENTRY until sensor after ARMED.
